// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel 2-FF synchroniser, stability counter, debounced level,
// press/release pulses and long-press detection. All outputs are registered.
module debounce_multi #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 1000000,
  parameter int                  HOLD_CYCLES   = 50000000,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = {CHANNELS{1'b0}}
) (
  input  logic                DebounceMulti_CLOCK_50,
  input  logic                DebounceMulti_Reset_InLow,
  input  logic [CHANNELS-1:0] DebounceMulti_Button_In,
  output logic [CHANNELS-1:0] DebounceMulti_Button_Out,
  output logic [CHANNELS-1:0] DebounceMulti_Press_Pulse,
  output logic [CHANNELS-1:0] DebounceMulti_Release_Pulse,
  output logic [CHANNELS-1:0] DebounceMulti_Long_Pulse,
  output logic [CHANNELS-1:0] DebounceMulti_Long_Level,
  output logic                DebounceMulti_Any_Event
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [SC_W-1:0] STAB_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(HOLD_CYCLES);

  logic [CHANNELS-1:0] sync1_r, sync2_r;
  logic [CHANNELS-1:0] level_r, press_r, release_r, long_pulse_r, long_level_r;
  logic [CHANNELS-1:0] level_s, press_s, release_s, long_pulse_s, long_level_s;
  logic                any_r, any_s;
  logic [SC_W-1:0]     stab_cnt_r [CHANNELS];
  logic [SC_W-1:0]     stab_cnt_s [CHANNELS];
  logic [HC_W-1:0]     hold_cnt_r [CHANNELS];
  logic [HC_W-1:0]     hold_cnt_s [CHANNELS];

  // Next-state for every channel: stability acceptance first, then long-press tracking.
  always_comb begin
    level_s      = level_r;
    long_level_s = long_level_r;
    press_s      = '0;
    release_s    = '0;
    long_pulse_s = '0;
    stab_cnt_s   = stab_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2_r[i] == level_r[i]) begin
        stab_cnt_s[i] = '0;
      end else if (stab_cnt_r[i] == STAB_LAST) begin
        level_s[i]    = sync2_r[i];
        stab_cnt_s[i] = '0;
        press_s[i]    = sync2_r[i];
        release_s[i]  = ~sync2_r[i];
      end else begin
        stab_cnt_s[i] = stab_cnt_r[i] + SC_W'(1);
      end

      // A release wins over a coinciding long-press: the press never reached full hold.
      if (press_s[i]) begin
        hold_cnt_s[i] = '0;
      end else if (release_s[i]) begin
        hold_cnt_s[i]   = '0;
        long_level_s[i] = 1'b0;
      end else if (!level_r[i]) begin
        hold_cnt_s[i] = '0;
      end else if (hold_cnt_r[i] < HOLD_MAX) begin
        hold_cnt_s[i] = hold_cnt_r[i] + HC_W'(1);
        if (hold_cnt_r[i] == HOLD_LAST) begin
          long_pulse_s[i] = 1'b1;
          long_level_s[i] = 1'b1;
        end else begin
          long_pulse_s[i] = 1'b0;
        end
      end else begin
        hold_cnt_s[i] = hold_cnt_r[i];
      end
    end
    any_s = |(press_s | release_s | long_pulse_s);
  end

  // State and output registers.
  always_ff @(posedge DebounceMulti_CLOCK_50 or negedge DebounceMulti_Reset_InLow) begin
    if (!DebounceMulti_Reset_InLow) begin
      sync1_r      <= '0;
      sync2_r      <= '0;
      level_r      <= '0;
      press_r      <= '0;
      release_r    <= '0;
      long_pulse_r <= '0;
      long_level_r <= '0;
      any_r        <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt_r[i] <= '0;
        hold_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r      <= DebounceMulti_Button_In ^ INVERT_MASK;
      sync2_r      <= sync1_r;
      level_r      <= level_s;
      press_r      <= press_s;
      release_r    <= release_s;
      long_pulse_r <= long_pulse_s;
      long_level_r <= long_level_s;
      any_r        <= any_s;
      stab_cnt_r   <= stab_cnt_s;
      hold_cnt_r   <= hold_cnt_s;
    end
  end

  assign DebounceMulti_Button_Out    = level_r;
  assign DebounceMulti_Press_Pulse   = press_r;
  assign DebounceMulti_Release_Pulse = release_r;
  assign DebounceMulti_Long_Pulse    = long_pulse_r;
  assign DebounceMulti_Long_Level    = long_level_r;
  assign DebounceMulti_Any_Event     = any_r;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bouncing inputs,
// every cycle compared against a window/timestamp reference model.
module tb_debounce_multi;

  localparam int          CH  = 4;
  localparam int          SC  = 4;
  localparam int          HC  = 16;
  localparam logic [3:0]  INV = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = INV;
  logic [3:0] btn_out, press_p, rel_p, long_p, long_l;
  logic       any_ev;

  debounce_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .INVERT_MASK(INV)
  ) dut (
    .DebounceMulti_CLOCK_50     (clk),
    .DebounceMulti_Reset_InLow  (rst_n),
    .DebounceMulti_Button_In    (btn_in),
    .DebounceMulti_Button_Out   (btn_out),
    .DebounceMulti_Press_Pulse  (press_p),
    .DebounceMulti_Release_Pulse(rel_p),
    .DebounceMulti_Long_Pulse   (long_p),
    .DebounceMulti_Long_Level   (long_l),
    .DebounceMulti_Any_Event    (any_ev)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: active-high input history per edge, press timestamps.
  logic [3:0] xq[$];
  int         e_m;
  int         press_t [CH];
  logic [3:0] out_m, press_m, rel_m, longp_m, longl_m;
  logic       any_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value the debouncer sees at edge k: the input sampled two edges earlier.
  function automatic logic dbit(input int ch, input int k);
    if (k < 2) return 1'b0;
    return xq[k-2][ch];
  endfunction

  task automatic model_reset();
    xq.delete();
    e_m = 0;
    out_m = '0; press_m = '0; rel_m = '0; longp_m = '0; longl_m = '0; any_m = 1'b0;
    for (int c = 0; c < CH; c++) press_t[c] = 0;
  endtask

  task automatic check_all();
    check_eq("out",     {28'd0, btn_out}, {28'd0, out_m});
    check_eq("press",   {28'd0, press_p}, {28'd0, press_m});
    check_eq("release", {28'd0, rel_p},   {28'd0, rel_m});
    check_eq("long_p",  {28'd0, long_p},  {28'd0, longp_m});
    check_eq("long_l",  {28'd0, long_l},  {28'd0, longl_m});
    check_eq("any",     {31'd0, any_ev},  {31'd0, any_m});
  endtask

  // One clock: drive active-high level x, advance the model, compare outputs.
  task automatic tick(input logic [3:0] x);
    btn_in = x ^ INV;
    @(posedge clk);
    xq.push_back(x);
    press_m = '0; rel_m = '0; longp_m = '0;
    for (int c = 0; c < CH; c++) begin
      logic flip;
      flip = (e_m >= SC - 1);
      for (int k = e_m - SC + 1; k <= e_m; k++)
        if (dbit(c, k) == out_m[c]) flip = 1'b0;
      if (flip) begin
        if (!out_m[c]) begin
          out_m[c] = 1'b1; press_m[c] = 1'b1; press_t[c] = e_m;
        end else begin
          out_m[c] = 1'b0; rel_m[c] = 1'b1; longl_m[c] = 1'b0;
        end
      end else if (out_m[c] && (e_m - press_t[c] == HC)) begin
        longp_m[c] = 1'b1; longl_m[c] = 1'b1;
      end
    end
    any_m = |(press_m | rel_m | longp_m);
    e_m++;
    #1;
    check_all();
  endtask

  logic [3:0] x_cur;
  int         rem [CH];
  logic [3:0] lvl;
  int         n;
  int         long_cnt;

  initial begin
    model_reset();
    x_cur = 4'b0000;
    btn_in = x_cur ^ INV;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #4 rst_n = 1'b1;

    repeat (3) tick(x_cur);

    // Clean press ch0: Out[0] must appear on the 6th edge.
    x_cur[0] = 1'b1;
    n = 99;
    for (int t = 1; t <= 20; t++) begin
      tick(x_cur);
      if (btn_out[0] && n == 99) n = t;
    end
    check_eq("lat_press0", n, 6);

    // Bounce on ch1 then steady high.
    for (int b = 0; b < 4; b++) begin
      x_cur[1] = (b % 2 == 0);
      repeat (2) tick(x_cur);
    end
    x_cur[1] = 1'b1;
    repeat (10) tick(x_cur);

    // Simultaneous: ch0 re-press and ch1 release on the same edge.
    x_cur[0] = 1'b0;
    repeat (8) tick(x_cur);
    x_cur[0] = 1'b1; x_cur[1] = 1'b0;
    repeat (8) tick(x_cur);

    // Long press ch2, then a short one.
    x_cur[2] = 1'b1;
    long_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      tick(x_cur);
      if (long_p[2]) long_cnt++;
    end
    check_eq("long_once", long_cnt, 1);
    x_cur[2] = 1'b0;
    repeat (10) tick(x_cur);
    x_cur[2] = 1'b1;
    repeat (10) tick(x_cur);
    x_cur[2] = 1'b0;
    repeat (10) tick(x_cur);

    // Inverted ch3 pressed (raw 0).
    x_cur[3] = 1'b1;
    repeat (10) tick(x_cur);
    x_cur[3] = 1'b0;
    repeat (10) tick(x_cur);

    // Random bouncy segments on every channel.
    lvl = x_cur;
    for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 25);
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          rem[c] = $urandom_range(1, 25);
        end
        rem[c]--;
        x_cur[c] = lvl[c];
        if (rem[c] > 6 && $urandom_range(0, 9) == 0) x_cur[c] = ~lvl[c];
      end
      tick(x_cur);
    end

    // Reset mid-count on ch0 (counter at 2), then full latency again.
    x_cur = 4'b0000;
    repeat (12) tick(x_cur);
    x_cur[0] = 1'b1;
    repeat (4) tick(x_cur);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    n = 99;
    for (int t = 1; t <= 20; t++) begin
      tick(x_cur);
      if (btn_out[0] && n == 99) n = t;
    end
    check_eq("lat_after_rst", n, 6);

    for (int t = 0; t < 300; t++) tick(4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
